fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of one `fifo` instance between `REQ_NUM` producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `BURST` words, then passes the port to the next requester in round-robin order. It sits directly in front of the FIFO's `wr_i`/`wrdata_i`/`full_o` pins and never writes while the FIFO reports full.

## Interface
Parameters:
- `DWIDTH`, 8: data word width; must match the FIFO's `DWIDTH`.
- `REQ_NUM`, 4: number of producers; 2..16.
- `BURST`, 4: maximum words accepted per grant; ≥1.

Ports:
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `srst_n_i`  in  1  synchronous, active-low reset.
- `req_valid_i`  in  REQ_NUM  producer k has a word; bit k belongs to producer k.
- `req_data_i`  in  REQ_NUM*DWIDTH  producer k's word at bits [k*DWIDTH +: DWIDTH].
- `req_last_i`  in  REQ_NUM  current word of producer k ends its burst.
- `req_ready_o`  out  REQ_NUM  word of producer k is accepted this cycle.
- `fifo_full_i`  in  1  from the FIFO's `full_o`.
- `fifo_wr_o`  out  1  to the FIFO's `wr_i`.
- `fifo_wrdata_o`  out  DWIDTH  to the FIFO's `wrdata_i`.
- `grant_o`  out  REQ_NUM  one-hot registered grant; all-zero when idle.
- `busy_o`  out  1  high while in the BURST state.

## Operation
- FSM has two states: IDLE and BURST. Registers are `state`, `grant` (one-hot), `ptr` (index, $clog2(REQ_NUM) bits) and `cnt` (burst word count, $clog2(BURST+1) bits).
- **IDLE, no valid requester:** stay in IDLE.
- **IDLE, any `req_valid_i` high:** select the first valid index searching ptr, ptr+1, … mod REQ_NUM. Register that one-hot into `grant`, clear `cnt`, go to BURST.
- **BURST, accept condition:** `acc = |(grant & req_valid_i) & ~fifo_full_i`.
- **BURST outputs:**
  - `fifo_wr_o = acc`.
  - `req_ready_o = grant & {REQ_NUM{~fifo_full_i}}`.
  - `fifo_wrdata_o` = granted producer's data.
- **BURST, on `acc`:** `cnt` increments.
- **BURST exit:** leave to IDLE after a cycle in which any of the following holds:
  - `acc` and `req_last_i[g]` is high;
  - `acc` and `cnt == BURST-1`;
  - `req_valid_i[g]` is low (producer abandoned the grant).
- **On exit:** `ptr <= (g+1) mod REQ_NUM` and `grant <= 0`.
- **Outside BURST:** `fifo_wr_o = 0`, `req_ready_o = 0`, `fifo_wrdata_o = 0`.
- **Full in BURST:** no accept, `cnt` holds and the grant is held, with no timeout. The FIFO therefore never sees `wr_i` while full.
- **Simultaneous `req_last_i` and `cnt == BURST-1`:** a single exit.
- **Ungranted producers:** their valid, last and data inputs are ignored and their ready is 0.
- **Protocol rule:** a producer must hold data and last stable while valid is high and ready is low. The bench checks this rule; the RTL does not.
- **Reset (`srst_n_i == 0` at a clock edge):** state returns to IDLE and `grant`, `ptr` and `cnt` go to 0. Every output is 0 in the cycle after the reset edge. A burst in progress is abandoned with no further writes.

## Timing
- **Arbitration latency:** valid first seen in IDLE at cycle t gives `grant_o`/`busy_o` at t+1. The first word can be written at t+1.
- **Write path:** combinational from `req_valid_i`/`fifo_full_i`/`grant` to `fifo_wr_o` and `req_ready_o`. There are no registers between the arbiter and the FIFO.
- **Throughput:** each grant costs one IDLE bubble. Peak is BURST/(BURST+1) words per cycle.
- **Fairness:** with all producers continuously valid, grants rotate 0,1,…,REQ_NUM-1,0. No producer waits more than REQ_NUM-1 grants.
- **Ignored in BURST:** the search happens only in IDLE, so new requests arriving in BURST do not affect the current grant.

## Test plan
- **Single burst, BURST=4:** producer 0 streams 6 words (0x10..0x15), last on 0x15, FIFO never full. Expect writes 0x10–0x13, then one IDLE cycle with `fifo_wr_o = 0`, then re-grant to 0 and writes 0x14–0x15, `grant_o = 0001` throughout both bursts.
- **Round-robin, REQ_NUM=4:** all producers valid with last on every word. Expect `grant_o` sequence 0001, 0010, 0100, 1000, 0001, with one write per grant, data equal to the producer index.
- **Backpressure:** assert `fifo_full_i` for 3 cycles mid-burst of producer 2. Expect `fifo_wr_o = 0` and `req_ready_o = 0` for those cycles, `grant_o = 0100` held and `cnt` unchanged. Expect no word lost or duplicated.
- **Abandon:** producer 1 drops valid after 1 of 4 words while producer 3 is valid. Expect release to IDLE, then `grant_o = 1000` two cycles after the drop.
- **Reset mid-burst:** assert `srst_n_i` low during word 2 of a burst. The next cycle must show all outputs 0. After release, arbitration restarts from producer 0.
- **Full at grant:** `fifo_full_i` is high when the grant is issued. Expect no write until full drops, then the burst completes normally.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one FIFO write port between REQ_NUM
// valid/ready producers, granting each a burst of up to BURST words.
module fifo_wr_arbiter #(
    parameter int DWIDTH  = 8,
    parameter int REQ_NUM = 4,
    parameter int BURST   = 4
) (
    input  logic                        clk_i,
    input  logic                        srst_n_i,
    input  logic [REQ_NUM-1:0]          req_valid_i,
    input  logic [REQ_NUM*DWIDTH-1:0]   req_data_i,
    input  logic [REQ_NUM-1:0]          req_last_i,
    output logic [REQ_NUM-1:0]          req_ready_o,
    input  logic                        fifo_full_i,
    output logic                        fifo_wr_o,
    output logic [DWIDTH-1:0]           fifo_wrdata_o,
    output logic [REQ_NUM-1:0]          grant_o,
    output logic                        busy_o
);
    localparam int PTR_W = $clog2(REQ_NUM);
    localparam int CNT_W = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t             state_reg, state_next;
    logic [REQ_NUM-1:0] grant_reg, grant_next;
    logic [PTR_W-1:0]   ptr_reg, ptr_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [DWIDTH-1:0]  masked_data [REQ_NUM];
    logic [DWIDTH-1:0]  granted_data;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_found;
    logic               in_burst;
    logic               valid_g;
    logic               last_g;
    logic               acc;

    genvar gi;
    generate
        for (gi = 0; gi < REQ_NUM; gi++) begin : g_mask
            assign masked_data[gi] = req_data_i[gi*DWIDTH +: DWIDTH] & {DWIDTH{grant_reg[gi]}};
        end
    endgenerate

    // Grant is one-hot, so an OR of the masked words is the granted word.
    always_comb begin
        granted_data = '0;
        grant_idx    = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            granted_data = granted_data | masked_data[i];
            if (grant_reg[i]) grant_idx = PTR_W'(i);
        end
    end

    // First valid requester searching ptr, ptr+1, ... with wrap at REQ_NUM.
    always_comb begin
        logic [PTR_W:0] cand;
        cand       = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            cand = (PTR_W+1)'(ptr_reg) + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(REQ_NUM)) cand = cand - (PTR_W+1)'(REQ_NUM);
            if (!pick_found && req_valid_i[cand[PTR_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign in_burst = (state_reg == ST_BURST);
    assign valid_g  = |(grant_reg & req_valid_i);
    assign last_g   = |(grant_reg & req_last_i);
    assign acc      = in_burst & valid_g & ~fifo_full_i;

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_next = REQ_NUM'(1) << pick_idx;
                    cnt_next   = '0;
                    state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                if (acc) cnt_next = cnt_reg + CNT_W'(1);
                // Full stalls hold the grant; only a finished or abandoned burst releases it.
                if ((acc && (last_g || cnt_reg == CNT_LAST)) || !valid_g) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                    ptr_next   = (grant_idx == PTR_W'(REQ_NUM - 1)) ? '0 : grant_idx + PTR_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        fifo_wr_o     = 1'b0;
        req_ready_o   = '0;
        fifo_wrdata_o = '0;
        if (in_burst) begin
            fifo_wr_o     = acc;
            req_ready_o   = grant_reg & {REQ_NUM{~fifo_full_i}};
            fifo_wrdata_o = granted_data;
        end
    end

    assign grant_o = grant_reg;
    assign busy_o  = in_burst;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: producer queues feed the DUT and a
// scoreboard of expected FIFO words is checked on every observed write.
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        srst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        full = 1'b0;
    logic        fifo_wr;
    logic [7:0]  fifo_wrdata;
    logic [3:0]  grant;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [8:0]  pmem [4][64];
    int          head [4];
    int          tail [4];
    logic [3:0]  en = '0;
    logic [7:0]  exp_q [$];

    fifo_wr_arbiter #(.DWIDTH(8), .REQ_NUM(4), .BURST(4)) dut (
        .clk_i(clk), .srst_n_i(srst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .fifo_full_i(full),
        .fifo_wr_o(fifo_wr), .fifo_wrdata_o(fifo_wrdata),
        .grant_o(grant), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Producer model: a word leaves its queue only after a valid&ready cycle,
    // so data and last stay put while a producer is stalled.
    always begin
        logic [3:0] tk;
        logic [8:0] w;
        @(negedge clk);
        tk = req_valid & req_ready;
        @(posedge clk);
        #2;
        for (int k = 0; k < 4; k++) begin
            if (tk[k]) head[k] = head[k] + 1;
            if (en[k] && head[k] != tail[k]) begin
                w = pmem[k][head[k] % 64];
                req_valid[k] = 1'b1;
                req_last[k]  = w[8];
                req_data[k*8 +: 8] = w[7:0];
            end else begin
                req_valid[k] = 1'b0;
                req_last[k]  = 1'b0;
                req_data[k*8 +: 8] = 8'h00;
            end
        end
    end

    task automatic load(input int k, input logic [8:0] w);
        pmem[k][tail[k] % 64] = w;
        tail[k] = tail[k] + 1;
    endtask

    task automatic bench_reset();
        @(posedge clk);
        #1;
        srst_n = 1'b0;
        full   = 1'b0;
        en     = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) tail[k] = head[k];
        exp_q.delete();
        srst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_w;
        srst_n = 1'b0;
        load(0, 9'h1AA);
        en[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fifo_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", fifo_wr); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        checks++; if (fifo_wrdata !== 8'h00) begin errors++; $display("FAIL reset_wrdata: got %h want 00", fifo_wrdata); end
        exp_q.push_back(8'hAA);
        @(posedge clk);
        #1 srst_n = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL release_idle_grant: got %b want 0000", grant); end
        @(negedge clk);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL latency_grant: got %b want 0001", grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy: got %b want 1", busy); end
        checks++; if (fifo_wr !== 1'b1) begin errors++; $display("FAIL latency_wr: got %b want 1", fifo_wr); end
        if (fifo_wr === 1'b1) begin
            checks++;
            exp_w = exp_q.pop_front();
            if (fifo_wrdata !== exp_w) begin errors++; $display("FAIL latency_data: got %h want %h", fifo_wrdata, exp_w); end
        end
        @(posedge clk);
        #1 en[0] = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL last_exit_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_burst();
        int eg [9] = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
        logic [7:0] exp_w;
        bench_reset();
        for (int i = 0; i < 6; i++) begin
            load(0, {i == 5, 8'(8'h10 + i)});
            exp_q.push_back(8'(8'h10 + i));
        end
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) en[0] = 1'b1;
            @(negedge clk);
            checks++; if (grant !== 4'(eg[c])) begin errors++; $display("FAIL single_burst_grant c%0d: got %b want %b", c, grant, 4'(eg[c])); end
            checks++; if (fifo_wr !== (eg[c] != 0)) begin errors++; $display("FAIL single_burst_wr c%0d: got %b want %b", c, fifo_wr, eg[c] != 0); end
            if (fifo_wr === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL single_burst_data c%0d: got %h want none", c, fifo_wrdata); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (fifo_wrdata !== exp_w) begin errors++; $display("FAIL single_burst_data c%0d: got %h want %h", c, fifo_wrdata, exp_w); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_burst_left: got %0d words unwritten want 0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic [7:0] exp_w;
        bench_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                load(k, {1'b1, 8'(k)});
                exp_q.push_back(8'(k));
            end
        end
        for (int c = 0; c < 17; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) en = 4'b1111;
            @(negedge clk);
            eg = (c % 2 == 1) ? 4'(1 << (((c - 1) / 2) % 4)) : 4'b0000;
            checks++; if (grant !== eg) begin errors++; $display("FAIL round_robin_grant c%0d: got %b want %b", c, grant, eg); end
            checks++; if (fifo_wr !== (c % 2 == 1)) begin errors++; $display("FAIL round_robin_wr c%0d: got %b want %b", c, fifo_wr, c % 2 == 1); end
            if (fifo_wr === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL round_robin_data c%0d: got %h want none", c, fifo_wrdata); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (fifo_wrdata !== exp_w) begin errors++; $display("FAIL round_robin_data c%0d: got %h want %h", c, fifo_wrdata, exp_w); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL round_robin_left: got %0d words unwritten want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int eg [11] = '{0, 4, 4, 4, 4, 4, 4, 4, 0, 4, 0};
        int ew [11] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0};
        logic [3:0] er;
        logic [7:0] exp_w;
        bench_reset();
        for (int i = 0; i < 5; i++) begin
            load(2, {i == 4, 8'(8'h20 + i)});
            exp_q.push_back(8'(8'h20 + i));
        end
        for (int c = 0; c < 11; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) en[2] = 1'b1;
            full = (c >= 3 && c <= 5);
            @(negedge clk);
            er = full ? 4'b0000 : 4'(eg[c]);
            checks++; if (grant !== 4'(eg[c])) begin errors++; $display("FAIL backpressure_grant c%0d: got %b want %b", c, grant, 4'(eg[c])); end
            checks++; if (fifo_wr !== 1'(ew[c])) begin errors++; $display("FAIL backpressure_wr c%0d: got %b want %b", c, fifo_wr, 1'(ew[c])); end
            checks++; if (req_ready !== er) begin errors++; $display("FAIL backpressure_ready c%0d: got %b want %b", c, req_ready, er); end
            if (fifo_wr === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL backpressure_data c%0d: got %h want none", c, fifo_wrdata); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (fifo_wrdata !== exp_w) begin errors++; $display("FAIL backpressure_data c%0d: got %h want %h", c, fifo_wrdata, exp_w); end
                end
            end
        end
        full = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL backpressure_left: got %0d words unwritten want 0", exp_q.size()); end
    endtask

    task automatic test_abandon();
        int eg [6] = '{0, 2, 2, 0, 8, 0};
        int ew [6] = '{0, 1, 0, 0, 1, 0};
        logic [7:0] exp_w;
        bench_reset();
        for (int i = 0; i < 4; i++) load(1, {i == 3, 8'(8'h30 + i)});
        load(3, 9'h140);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h40);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) en = 4'b1010;
            if (c == 2) en[1] = 1'b0;
            @(negedge clk);
            checks++; if (grant !== 4'(eg[c])) begin errors++; $display("FAIL abandon_grant c%0d: got %b want %b", c, grant, 4'(eg[c])); end
            checks++; if (fifo_wr !== 1'(ew[c])) begin errors++; $display("FAIL abandon_wr c%0d: got %b want %b", c, fifo_wr, 1'(ew[c])); end
            if (fifo_wr === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL abandon_data c%0d: got %h want none", c, fifo_wrdata); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (fifo_wrdata !== exp_w) begin errors++; $display("FAIL abandon_data c%0d: got %h want %h", c, fifo_wrdata, exp_w); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abandon_left: got %0d words unwritten want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_burst();
        int eg [12] = '{0, 2, 0, 4, 4, 0, 0, 1, 0, 4, 4, 0};
        int ew [12] = '{0, 1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0};
        logic [7:0] exp_w;
        bench_reset();
        load(1, 9'h14F);
        for (int i = 0; i < 4; i++) load(2, {i == 3, 8'(8'h50 + i)});
        load(0, 9'h170);
        exp_q.push_back(8'h4F);
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h70);
        exp_q.push_back(8'h52);
        exp_q.push_back(8'h53);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) en[1] = 1'b1;
            if (c == 2) begin en[0] = 1'b1; en[2] = 1'b1; end
            if (c == 4) srst_n = 1'b0;
            if (c == 6) srst_n = 1'b1;
            @(negedge clk);
            checks++; if (grant !== 4'(eg[c])) begin errors++; $display("FAIL reset_mid_grant c%0d: got %b want %b", c, grant, 4'(eg[c])); end
            checks++; if (fifo_wr !== 1'(ew[c])) begin errors++; $display("FAIL reset_mid_wr c%0d: got %b want %b", c, fifo_wr, 1'(ew[c])); end
            if (c == 5) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
                checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_mid_ready: got %b want 0000", req_ready); end
                checks++; if (fifo_wrdata !== 8'h00) begin errors++; $display("FAIL reset_mid_wrdata: got %h want 00", fifo_wrdata); end
            end
            if (fifo_wr === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL reset_mid_data c%0d: got %h want none", c, fifo_wrdata); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (fifo_wrdata !== exp_w) begin errors++; $display("FAIL reset_mid_data c%0d: got %h want %h", c, fifo_wrdata, exp_w); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reset_mid_left: got %0d words unwritten want 0", exp_q.size()); end
    endtask

    task automatic test_full_at_grant();
        int eg [6] = '{0, 8, 8, 8, 8, 0};
        int ew [6] = '{0, 0, 0, 1, 1, 0};
        logic [3:0] er;
        logic [7:0] exp_w;
        bench_reset();
        load(3, 9'h080);
        load(3, 9'h181);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h81);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) en[3] = 1'b1;
            full = (c < 3);
            @(negedge clk);
            er = full ? 4'b0000 : 4'(eg[c]);
            checks++; if (grant !== 4'(eg[c])) begin errors++; $display("FAIL full_at_grant_grant c%0d: got %b want %b", c, grant, 4'(eg[c])); end
            checks++; if (fifo_wr !== 1'(ew[c])) begin errors++; $display("FAIL full_at_grant_wr c%0d: got %b want %b", c, fifo_wr, 1'(ew[c])); end
            checks++; if (req_ready !== er) begin errors++; $display("FAIL full_at_grant_ready c%0d: got %b want %b", c, req_ready, er); end
            if (fifo_wr === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL full_at_grant_data c%0d: got %h want none", c, fifo_wrdata); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (fifo_wrdata !== exp_w) begin errors++; $display("FAIL full_at_grant_data c%0d: got %h want %h", c, fifo_wrdata, exp_w); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_at_grant_left: got %0d words unwritten want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_abandon();
        test_reset_mid_burst();
        test_full_at_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
